// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- hazard and forwarding scheduler for the EX stage.
//
// Keeps a shadow copy of the destination registers of in-flight
// instructions and uses it to pick EX operand forwarding sources (registered,
// aligned with the ID/EX register). It also sequences load-use stalls,
// taken-branch flushes and external freezes for IF/ID and ID/EX.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   ID_rs1/ID_rs2              source addresses of the instruction in ID
//   ID_use_rs1/ID_use_rs2      instruction in ID actually reads that source
//   ID_AddrD/ID_RegWEn         destination and write enable of the ID instr
//   ID_WBSel                   writeback select (LOAD_WBSEL marks a load)
//   branch_taken               EX resolved a taken branch/jump this cycle
//   hold                       external freeze (memory wait)
//   ForwardingA/ForwardingB    00 DataA, 01 DataWB, 10 DataM, 11 Data_W_delay
//   stall_pc, stall_if_id      hold PC / IF/ID register
//   flush_if_id, flush_id_ex   load a bubble into IF/ID / ID/EX
module ex_hazard_ctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter logic [1:0]  LOAD_WBSEL = 2'b00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ID_rs1,
  input  logic [ADDR_W-1:0] ID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [ADDR_W-1:0] ID_AddrD,
  input  logic              ID_RegWEn,
  input  logic [1:0]        ID_WBSel,
  input  logic              branch_taken,
  input  logic              hold,
  output logic [1:0]        ForwardingA,
  output logic [1:0]        ForwardingB,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex
);

  // Shadow slots. The stage after wb has already committed its write by the
  // time a consumer could read it, so it never sources a forward and is not
  // stored; likewise only the ex slot needs its is_load flag.
  logic              ex_valid, ex_load;
  logic [ADDR_W-1:0] ex_rd;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;

  logic ex_writer, mem_writer, wb_writer;
  logic load_use;

  assign ex_writer  = ex_valid  && (ex_rd  != '0);
  assign mem_writer = mem_valid && (mem_rd != '0);
  assign wb_writer  = wb_valid  && (wb_rd  != '0);

  // Slot positions now map to the stage the producer occupies next cycle:
  // ex -> MEM (10), mem -> WB (01), wb -> W_delay (11). Youngest wins.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] rs,
    input logic              use_rs,
    input logic              exw,
    input logic [ADDR_W-1:0] exrd,
    input logic              memw,
    input logic [ADDR_W-1:0] memrd,
    input logic              wbw,
    input logic [ADDR_W-1:0] wbrd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && (rs != '0)) begin
      if (exw && (exrd == rs))        sel = 2'b10;
      else if (memw && (memrd == rs)) sel = 2'b01;
      else if (wbw && (wbrd == rs))   sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_writer && ex_load &&
               (((ex_rd == ID_rs1) && ID_use_rs1) ||
                ((ex_rd == ID_rs2) && ID_use_rs2));
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    // Gated by reset_n so a reset mid-stall idles the outputs immediately,
    // even while hold or branch_taken are still asserted.
    if (!reset_n) begin
      stall_pc = 1'b0;
    end else if (hold) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_load     <= 1'b0;
      ex_rd       <= '0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      ForwardingA <= 2'b00;
      ForwardingB <= 2'b00;
    end else if (!hold) begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      if (flush_id_ex) begin
        ex_valid    <= 1'b0;
        ex_load     <= 1'b0;
        ex_rd       <= '0;
        ForwardingA <= 2'b00;
        ForwardingB <= 2'b00;
      end else begin
        ex_valid    <= ID_RegWEn;
        ex_load     <= (ID_WBSel == LOAD_WBSEL);
        ex_rd       <= ID_AddrD;
        ForwardingA <= fwd_sel(ID_rs1, ID_use_rs1, ex_writer, ex_rd,
                               mem_writer, mem_rd, wb_writer, wb_rd);
        ForwardingB <= fwd_sel(ID_rs2, ID_use_rs2, ex_writer, ex_rd,
                               mem_writer, mem_rd, wb_writer, wb_rd);
      end
    end
  end

endmodule
